id_decode_queue: RTL and testbench

//  Parametrised decode stage: buffers fetched instructions (with PC) in a DEPTH-entry FIFO,

---
 rtl/id_decode_queue.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_id_decode_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// ---------------------------------------------------------------------------
// id_decode_queue
//   Decode stage between IF and EX. Fetched instructions and their PCs are
//   buffered in a DEPTH-entry FIFO. The head entry is split into MIPS fields,
//   and its control word is produced by a combinational id_control instance.
//   Both are registered into a single output slot that has a valid/ready
//   handshake. The queue decouples fetch from EX stalls, and a flush discards
//   everything in flight.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   flush                      drop queue contents and output slot
//   in_valid/in_ready          fetch handshake (in_inst, in_pc)
//   out_valid/out_ready        EX handshake for the output slot
//   out_pc, out_rs/rt/rd,      decoded fields of the slot instruction
//   out_shamt, out_imm,
//   out_imm_ext, out_instr_index
//   RegWrite..ALUOp            control word of the slot instruction
//   count                      FIFO occupancy (output slot not included)
// ---------------------------------------------------------------------------

// Combinational MIPS main control. R-type instructions pass funct through as
// the ALU operation; all other opcodes pass the opcode itself.
module id_control (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic       reg_write_o,
    output logic       alu_src_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic [1:0] reg_dst_o,     // 00 rt, 01 rd, 10 $ra
    output logic [5:0] alu_op_o
);
    always_comb begin
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_dst_o    = 2'b00;
        alu_op_o     = op_i;
        unique case (op_i)
            6'h00: begin                           // R-type
                reg_write_o = 1'b1;
                reg_dst_o   = 2'b01;
                alu_op_o    = funct_i;
            end
            6'h23: begin                           // lw
                reg_write_o  = 1'b1;
                alu_src_o    = 1'b1;
                mem_read_o   = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            6'h2B: begin                           // sw
                alu_src_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin      // immediate ALU ops, lui
                reg_write_o = 1'b1;
                alu_src_o   = 1'b1;
            end
            6'h04, 6'h05: begin                    // beq, bne: compare regs
                alu_src_o = 1'b0;
            end
            6'h03: begin                           // jal writes $ra
                reg_write_o = 1'b1;
                reg_dst_o   = 2'b10;
            end
            default: begin                         // j and unknown: no effect
                alu_op_o = op_i;
            end
        endcase
    end
endmodule

module id_decode_queue #(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter bit ZEXT_LOGIC = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_shamt,
    output logic [15:0]                out_imm,
    output logic [DATA_W-1:0]          out_imm_ext,
    output logic [25:0]                out_instr_index,
    output logic                       RegWrite,
    output logic                       ALUSrc,
    output logic                       MemRead,
    output logic                       MemWrite,
    output logic                       MemToReg,
    output logic [1:0]                 RegDst,
    output logic [5:0]                 ALUOp,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = PC_W + 32;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Output slot
    logic              out_valid_q, out_valid_d;
    logic [31:0]       inst_q,      inst_d;
    logic [PC_W-1:0]   pc_q,        pc_d;
    logic [DATA_W-1:0] imm_ext_q,   imm_ext_d;
    logic              reg_write_q, reg_write_d;
    logic              alu_src_q,   alu_src_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [1:0]        reg_dst_q,   reg_dst_d;
    logic [5:0]        alu_op_q,    alu_op_d;

    logic              full;
    logic              push;
    logic              load;
    logic [ENT_W-1:0]  head;
    logic [31:0]       head_inst;
    logic [PC_W-1:0]   head_pc;
    logic              head_zext;
    logic [DATA_W-1:0] head_imm_ext;

    logic              c_reg_write;
    logic              c_alu_src;
    logic              c_mem_read;
    logic              c_mem_write;
    logic              c_mem_to_reg;
    logic [1:0]        c_reg_dst;
    logic [5:0]        c_alu_op;

    // Ready depends on occupancy only, never on a same-cycle load, so that
    // in_ready has no combinational path from out_ready.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign in_ready = !full && !rst;

    assign push = in_valid && in_ready && !flush;
    assign load = (count_q != '0) && (!out_valid_q || out_ready) && !flush;

    assign head      = mem_q[rd_ptr_q];
    assign head_inst = head[31:0];
    assign head_pc   = head[ENT_W-1:32];

    // Logical immediates (andi/ori/xori) are zero-extended when enabled.
    assign head_zext = ZEXT_LOGIC &&
                       ((head_inst[31:26] == 6'h0C) ||
                        (head_inst[31:26] == 6'h0D) ||
                        (head_inst[31:26] == 6'h0E));

    always_comb begin
        if (head_zext) begin
            head_imm_ext = {{(DATA_W-16){1'b0}}, head_inst[15:0]};
        end else begin
            head_imm_ext = {{(DATA_W-16){head_inst[15]}}, head_inst[15:0]};
        end
    end

    id_control u_ctrl (
        .op_i         (head_inst[31:26]),
        .funct_i      (head_inst[5:0]),
        .reg_write_o  (c_reg_write),
        .alu_src_o    (c_alu_src),
        .mem_read_o   (c_mem_read),
        .mem_write_o  (c_mem_write),
        .mem_to_reg_o (c_mem_to_reg),
        .reg_dst_o    (c_reg_dst),
        .alu_op_o     (c_alu_op)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        imm_ext_d    = imm_ext_q;
        reg_write_d  = reg_write_q;
        alu_src_d    = alu_src_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_dst_d    = reg_dst_q;
        alu_op_d     = alu_op_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (load) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            out_valid_d  = 1'b1;
            inst_d       = head_inst;
            pc_d         = head_pc;
            imm_ext_d    = head_imm_ext;
            reg_write_d  = c_reg_write;
            alu_src_d    = c_alu_src;
            mem_read_d   = c_mem_read;
            mem_write_d  = c_mem_write;
            mem_to_reg_d = c_mem_to_reg;
            reg_dst_d    = c_reg_dst;
            alu_op_d     = c_alu_op;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (push && !load) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && load) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            inst_q       <= '0;
            pc_q         <= '0;
            imm_ext_q    <= '0;
            reg_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_dst_q    <= 2'b00;
            alu_op_q     <= 6'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            imm_ext_q    <= imm_ext_d;
            reg_write_q  <= reg_write_d;
            alu_src_q    <= alu_src_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_dst_q    <= reg_dst_d;
            alu_op_q     <= alu_op_d;
        end
    end

    // Storage needs no reset: push is blocked during reset and entries are
    // only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_pc, in_inst};
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = pc_q;
    assign out_rs          = inst_q[25:21];
    assign out_rt          = inst_q[20:16];
    assign out_rd          = inst_q[15:11];
    assign out_shamt       = inst_q[10:6];
    assign out_imm         = inst_q[15:0];
    assign out_imm_ext     = imm_ext_q;
    assign out_instr_index = inst_q[25:0];
    assign count           = count_q;

    // Side-effecting controls are masked when the slot is empty, so EX sees
    // a NOP on a bubble even though the slot registers still hold old data.
    assign RegWrite = reg_write_q  && out_valid_q;
    assign MemRead  = mem_read_q   && out_valid_q;
    assign MemWrite = mem_write_q  && out_valid_q;
    assign MemToReg = mem_to_reg_q && out_valid_q;
    assign ALUSrc   = alu_src_q;
    assign RegDst   = reg_dst_q;
    assign ALUOp    = alu_op_q;
endmodule

// File: tb/tb_id_decode_queue.sv
module tb_id_decode_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm;
    logic [31:0] out_imm_ext;
    logic [25:0] out_instr_index;
    logic        RegWrite, ALUSrc, MemRead, MemWrite, MemToReg;
    logic [1:0]  RegDst;
    logic [5:0]  ALUOp;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    id_decode_queue #(.DEPTH(4), .PC_W(32), .DATA_W(32), .ZEXT_LOGIC(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_imm_ext(out_imm_ext), .out_instr_index(out_instr_index),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .ALUOp(ALUOp), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [31:0] exp_pc_q[$];
    logic [25:0] exp_idx_q[$];
    logic [31:0] e_pc;
    logic [25:0] e_idx;
    int          sent;
    int          rcvd;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;

        // Reset
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_regwrite", RegWrite, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Decode lw $2,4($1)
        in_valid = 1'b1; in_inst = 32'h8C220004; in_pc = 32'h100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lw_count_after_push", count, 1);
        chk("lw_not_yet_valid", out_valid, 0);
        tick();
        chk("lw_valid", out_valid, 1);
        chk("lw_rs", out_rs, 1);
        chk("lw_rt", out_rt, 2);
        chk("lw_imm", out_imm, 16'h0004);
        chk("lw_imm_ext", out_imm_ext, 32'h00000004);
        chk("lw_memread", MemRead, 1);
        chk("lw_memtoreg", MemToReg, 1);
        chk("lw_regwrite", RegWrite, 1);
        chk("lw_alusrc", ALUSrc, 1);
        chk("lw_regdst", RegDst, 0);
        chk("lw_memwrite", MemWrite, 0);
        chk("lw_aluop", ALUOp, 6'h23);
        chk("lw_pc", out_pc, 32'h100);
        tick();
        chk("lw_consumed", out_valid, 0);
        chk("bubble_memread", MemRead, 0);
        chk("bubble_regwrite", RegWrite, 0);

        // Extension: ori zero-extends, addi sign-extends
        in_valid = 1'b1; in_inst = 32'h3421FFFF; in_pc = 32'h104;
        tick();
        in_inst = 32'h2021FFFF; in_pc = 32'h108;
        tick();
        in_valid = 1'b0;
        chk("ori_valid", out_valid, 1);
        chk("ori_imm_ext", out_imm_ext, 32'h0000FFFF);
        chk("ori_pc", out_pc, 32'h104);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_imm_ext", out_imm_ext, 32'hFFFFFFFF);
        chk("addi_pc", out_pc, 32'h108);
        tick();
        chk("ext_drained", out_valid, 0);

        // Backpressure / full
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_inst = 32'h20420000 | i; in_pc = 32'h200 + 4 * i;
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_slot_valid", out_valid, 1);
        chk("full_slot_pc", out_pc, 32'h200);
        chk("full_slot_imm", out_imm, 0);
        tick();
        chk("hold_slot_pc", out_pc, 32'h200);
        chk("hold_count", count, 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_pc", out_pc, 32'h200 + 4 * i);
            chk("drain_imm", out_imm, i);
            chk("drain_valid", out_valid, 1);
        end
        tick();
        chk("drain_done_valid", out_valid, 0);
        chk("drain_done_count", count, 0);

        // Wrap: 20 instructions with random out_ready
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
            if (sent < 20) begin
                in_valid = 1'b1;
                in_inst  = $urandom;
                in_pc    = 32'h1000 + 4 * sent;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                exp_pc_q.push_back(in_pc);
                exp_idx_q.push_back(in_inst[25:0]);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_pc_q.size() == 0) begin
                    chk("wrap_unexpected_output", 1, 0);
                end else begin
                    e_pc  = exp_pc_q.pop_front();
                    e_idx = exp_idx_q.pop_front();
                    chk("wrap_pc", out_pc, e_pc);
                    chk("wrap_index", out_instr_index, e_idx);
                end
                rcvd++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_received", rcvd, 20);

        // Flush
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = 32'h00430820; in_pc = 32'h300 + 4 * i;
            tick();
        end
        chk("preflush_count", count, 3);
        chk("preflush_valid", out_valid, 1);
        chk("preflush_regwrite", RegWrite, 1);
        chk("preflush_regdst", RegDst, 2'b01);
        chk("preflush_aluop", ALUOp, 6'h20);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h8C220004; in_pc = 32'h3F0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_count", count, 0);
        chk("flush_regwrite", RegWrite, 0);
        chk("flush_in_ready", in_ready, 1);
        tick(); tick();
        chk("flush_discard_count", count, 0);
        chk("flush_discard_valid", out_valid, 0);
        in_valid = 1'b1; in_inst = 32'h3421ABCD; in_pc = 32'h400; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("postflush_valid", out_valid, 1);
        chk("postflush_pc", out_pc, 32'h400);
        chk("postflush_imm_ext", out_imm_ext, 32'h0000ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
